// File: rtl/pipe_ctrl_pkg.sv
// Shared encodings for the pipeline sequencing controller: FSM states,
// forwarding selects and the mult/div function codes seen by the decoder.
package pipe_ctrl_pkg;

    localparam int unsigned REG_W = 5;
    localparam int unsigned SEL_W = 2;

    localparam logic [1:0] PC_RUN       = 2'd0;
    localparam logic [1:0] PC_LOAD_WAIT = 2'd1;
    localparam logic [1:0] PC_MD_WAIT   = 2'd2;

    localparam logic [SEL_W-1:0] FWD_RF  = 2'b00;
    localparam logic [SEL_W-1:0] FWD_EXE = 2'b01;
    localparam logic [SEL_W-1:0] FWD_MEM = 2'b10;

    localparam logic [5:0] FUNC_MULT  = 6'h18;
    localparam logic [5:0] FUNC_MULTU = 6'h19;
    localparam logic [5:0] FUNC_DIV   = 6'h1a;
    localparam logic [5:0] FUNC_DIVU  = 6'h1b;

    // Decoder helper: R-type func field selects a multi-cycle mult/div op.
    function automatic logic is_muldiv_func(input logic [5:0] func);
        return (func == FUNC_MULT) || (func == FUNC_MULTU) ||
               (func == FUNC_DIV)  || (func == FUNC_DIVU);
    endfunction

endpackage

// File: rtl/pipe_ctrl_fwd_sel.sv
// Forwarding source select for one ID operand; EXE beats MEM, $0 never matches.
module pipe_ctrl_fwd_sel
    import pipe_ctrl_pkg::*;
(
    input  logic [REG_W-1:0] src,
    input  logic             rena,
    input  logic [REG_W-1:0] exe_waddr,
    input  logic             exe_wena,
    input  logic [REG_W-1:0] mem_waddr,
    input  logic             mem_wena,
    output logic             exe_match_c,
    output logic [SEL_W-1:0] sel_c
);

    logic mem_match;

    always_comb begin
        exe_match_c = exe_wena && rena && (exe_waddr == src) && (exe_waddr != REG_W'(0));
        mem_match   = mem_wena && rena && (mem_waddr == src) && (mem_waddr != REG_W'(0));
        sel_c       = FWD_RF;
        if (exe_match_c) begin
            sel_c = FWD_EXE;
        end else if (mem_match) begin
            sel_c = FWD_MEM;
        end
    end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline sequencing controller: load-use interlock, mult/div issue with
// timeout watchdog, branch squash, forwarding selects and perf counters.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned MD_TIMEOUT = 40,
    parameter int unsigned CNT_W      = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 id_valid,
    input  logic [REG_W-1:0]     id_rs,
    input  logic [REG_W-1:0]     id_rt,
    input  logic                 id_rena1,
    input  logic                 id_rena2,
    input  logic                 id_is_muldiv,
    input  logic                 branch_taken,
    input  logic [REG_W-1:0]     exe_waddr,
    input  logic                 exe_wena,
    input  logic                 exe_is_load,
    input  logic [REG_W-1:0]     mem_waddr,
    input  logic                 mem_wena,
    input  logic                 muldiv_done,
    output logic                 pc_stall,
    output logic                 if_id_stall,
    output logic                 id_exe_bubble,
    output logic                 if_id_flush,
    output logic                 muldiv_start,
    output logic [SEL_W-1:0]     fwd_rs_sel,
    output logic [SEL_W-1:0]     fwd_rt_sel,
    output logic                 md_err,
    output logic [CNT_W-1:0]     stall_cycles,
    output logic [15:0]          flush_count
);

    localparam int unsigned MD_CNT_W = $clog2(MD_TIMEOUT + 1);

    logic [1:0]          state_q, state_d;
    logic [MD_CNT_W-1:0] md_cnt_q, md_cnt_d;
    logic                md_err_q, md_err_d;
    logic [CNT_W-1:0]    stall_cycles_q, stall_cycles_d;
    logic [15:0]         flush_count_q, flush_count_d;

    logic             rs_exe_match, rt_exe_match;
    logic [SEL_W-1:0] rs_sel, rt_sel;
    logic             load_use;
    logic             stall_all;

    pipe_ctrl_fwd_sel u_fwd_rs (
        .src         (id_rs),
        .rena        (id_rena1),
        .exe_waddr   (exe_waddr),
        .exe_wena    (exe_wena),
        .mem_waddr   (mem_waddr),
        .mem_wena    (mem_wena),
        .exe_match_c (rs_exe_match),
        .sel_c       (rs_sel)
    );

    pipe_ctrl_fwd_sel u_fwd_rt (
        .src         (id_rt),
        .rena        (id_rena2),
        .exe_waddr   (exe_waddr),
        .exe_wena    (exe_wena),
        .mem_waddr   (mem_waddr),
        .mem_wena    (mem_wena),
        .exe_match_c (rt_exe_match),
        .sel_c       (rt_sel)
    );

    // Load-use only interlocks from RUN; in LOAD_WAIT the load has moved to MEM.
    assign load_use = id_valid && exe_is_load && (rs_exe_match || rt_exe_match) &&
                      (state_q == PC_RUN);

    always_comb begin
        state_d      = state_q;
        md_cnt_d     = md_cnt_q;
        md_err_d     = md_err_q;
        stall_all    = 1'b0;
        if_id_flush  = 1'b0;
        muldiv_start = 1'b0;

        case (state_q)
            PC_RUN, PC_LOAD_WAIT: begin
                if (load_use) begin
                    stall_all = 1'b1;
                    state_d   = PC_LOAD_WAIT;
                end else if (id_valid && id_is_muldiv) begin
                    stall_all    = 1'b1;
                    muldiv_start = 1'b1;
                    md_cnt_d     = '0;
                    state_d      = PC_MD_WAIT;
                end else begin
                    if_id_flush = branch_taken;
                    state_d     = PC_RUN;
                end
            end
            PC_MD_WAIT: begin
                // Done wins over a coincident timeout; either releases ID this cycle.
                if (muldiv_done) begin
                    state_d = PC_RUN;
                end else if (md_cnt_q == MD_CNT_W'(MD_TIMEOUT - 1)) begin
                    md_err_d = 1'b1;
                    state_d  = PC_RUN;
                end else begin
                    stall_all = 1'b1;
                    md_cnt_d  = md_cnt_q + MD_CNT_W'(1);
                end
            end
            default: state_d = PC_RUN;
        endcase

        if (rst) begin
            stall_all    = 1'b0;
            if_id_flush  = 1'b0;
            muldiv_start = 1'b0;
        end

        pc_stall      = stall_all;
        if_id_stall   = stall_all;
        id_exe_bubble = stall_all;
        fwd_rs_sel    = rst ? FWD_RF : rs_sel;
        fwd_rt_sel    = rst ? FWD_RF : rt_sel;

        stall_cycles_d = stall_cycles_q + CNT_W'(stall_all);
        flush_count_d  = flush_count_q;
        if (if_id_flush && (flush_count_q != 16'hFFFF)) begin
            flush_count_d = flush_count_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= PC_RUN;
            md_cnt_q       <= '0;
            md_err_q       <= 1'b0;
            stall_cycles_q <= '0;
            flush_count_q  <= '0;
        end else begin
            state_q        <= state_d;
            md_cnt_q       <= md_cnt_d;
            md_err_q       <= md_err_d;
            stall_cycles_q <= stall_cycles_d;
            flush_count_q  <= flush_count_d;
        end
    end

    assign md_err       = md_err_q;
    assign stall_cycles = stall_cycles_q;
    assign flush_count  = flush_count_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: interlocks, forwarding, mult/div sequencing, counters.
module tb_pipe_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        id_valid, id_rena1, id_rena2, id_is_muldiv, branch_taken;
    logic [4:0]  id_rs, id_rt, exe_waddr, mem_waddr;
    logic        exe_wena, exe_is_load, mem_wena, muldiv_done;
    logic        pc_stall, if_id_stall, id_exe_bubble, if_id_flush, muldiv_start, md_err;
    logic [1:0]  fwd_rs_sel, fwd_rt_sel;
    logic [31:0] stall_cycles;
    logic [15:0] flush_count;

    int checks = 0;
    int fails  = 0;

    always #5 clk = ~clk;

    pipe_ctrl #(.MD_TIMEOUT(40), .CNT_W(32)) dut (
        .clk(clk), .rst(rst),
        .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_rena1(id_rena1), .id_rena2(id_rena2), .id_is_muldiv(id_is_muldiv),
        .branch_taken(branch_taken),
        .exe_waddr(exe_waddr), .exe_wena(exe_wena), .exe_is_load(exe_is_load),
        .mem_waddr(mem_waddr), .mem_wena(mem_wena), .muldiv_done(muldiv_done),
        .pc_stall(pc_stall), .if_id_stall(if_id_stall), .id_exe_bubble(id_exe_bubble),
        .if_id_flush(if_id_flush), .muldiv_start(muldiv_start),
        .fwd_rs_sel(fwd_rs_sel), .fwd_rt_sel(fwd_rt_sel),
        .md_err(md_err), .stall_cycles(stall_cycles), .flush_count(flush_count)
    );

    task automatic idle();
        id_valid = 0; id_rs = 0; id_rt = 0; id_rena1 = 0; id_rena2 = 0;
        id_is_muldiv = 0; branch_taken = 0;
        exe_waddr = 0; exe_wena = 0; exe_is_load = 0;
        mem_waddr = 0; mem_wena = 0; muldiv_done = 0;
    endtask

    // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        idle();
        rst = 1;
        tick();
        tick();
        rst = 0;
    endtask

    task automatic test_reset();
        rst = 1;
        id_valid = 1; id_rs = 5'd8; id_rt = 5'd9; id_rena1 = 1; id_rena2 = 1;
        id_is_muldiv = 1; branch_taken = 1;
        exe_waddr = 5'd8; exe_wena = 1; exe_is_load = 1;
        mem_waddr = 5'd9; mem_wena = 1; muldiv_done = 1;
        tick();
        tick();
        checks++;
        if ({pc_stall, if_id_stall, id_exe_bubble, if_id_flush, muldiv_start} !== 5'b0) begin
            fails++;
            $display("FAIL reset_ctrl got %b exp 00000",
                     {pc_stall, if_id_stall, id_exe_bubble, if_id_flush, muldiv_start});
        end
        checks++;
        if ({fwd_rs_sel, fwd_rt_sel} !== 4'b0) begin
            fails++;
            $display("FAIL reset_fwd got %b exp 0000", {fwd_rs_sel, fwd_rt_sel});
        end
        rst = 0;
        idle();
        #1;
        checks++;
        if (stall_cycles !== 32'd0 || flush_count !== 16'd0 || md_err !== 1'b0 || pc_stall !== 1'b0) begin
            fails++;
            $display("FAIL reset_state got sc=%0d fc=%0d err=%b st=%b exp 0 0 0 0",
                     stall_cycles, flush_count, md_err, pc_stall);
        end
    endtask

    task automatic test_load_use();
        do_reset();
        exe_is_load = 1; exe_wena = 1; exe_waddr = 5'd8;
        id_valid = 1; id_rs = 5'd8; id_rena1 = 1;
        #1;
        checks++;
        if ({pc_stall, if_id_stall, id_exe_bubble, fwd_rs_sel} !== 5'b11101) begin
            fails++;
            $display("FAIL load_use_c0 got %b exp 11101", {pc_stall, if_id_stall, id_exe_bubble, fwd_rs_sel});
        end
        tick();
        exe_is_load = 0; exe_wena = 0; exe_waddr = 0;
        mem_waddr = 5'd8; mem_wena = 1;
        #1;
        checks++;
        if ({pc_stall, fwd_rs_sel} !== 3'b010) begin
            fails++;
            $display("FAIL load_use_c1 got %b exp 010", {pc_stall, fwd_rs_sel});
        end
        tick();
        idle();
        checks++;
        if (stall_cycles !== 32'd1) begin
            fails++;
            $display("FAIL load_use_cnt got %0d exp 1", stall_cycles);
        end
    endtask

    task automatic test_zero_reg_fwd();
        idle();
        exe_is_load = 1; exe_wena = 1; exe_waddr = 0;
        id_valid = 1; id_rs = 0; id_rena1 = 1;
        #1;
        checks++;
        if ({pc_stall, fwd_rs_sel} !== 3'b000) begin
            fails++;
            $display("FAIL zero_reg got %b exp 000", {pc_stall, fwd_rs_sel});
        end
        exe_is_load = 0; exe_waddr = 5'd5; mem_waddr = 5'd5; mem_wena = 1;
        id_rt = 5'd5; id_rena2 = 1;
        #1;
        checks++;
        if (fwd_rt_sel !== 2'b01) begin
            fails++;
            $display("FAIL fwd_exe_prio got %b exp 01", fwd_rt_sel);
        end
        exe_wena = 0;
        #1;
        checks++;
        if (fwd_rt_sel !== 2'b10) begin
            fails++;
            $display("FAIL fwd_mem got %b exp 10", fwd_rt_sel);
        end
        id_rena2 = 0;
        #1;
        checks++;
        if (fwd_rt_sel !== 2'b00) begin
            fails++;
            $display("FAIL fwd_rena_off got %b exp 00", fwd_rt_sel);
        end
        tick();
        idle();
    endtask

    task automatic test_muldiv_done();
        int bad = 0;
        do_reset();
        id_valid = 1; id_is_muldiv = 1;
        #1;
        checks++;
        if ({muldiv_start, pc_stall, id_exe_bubble} !== 3'b111) begin
            fails++;
            $display("FAIL md_issue got %b exp 111", {muldiv_start, pc_stall, id_exe_bubble});
        end
        tick();
        for (int i = 0; i < 10; i++) begin
            if (muldiv_start !== 1'b0 || pc_stall !== 1'b1) bad++;
            tick();
        end
        checks++;
        if (bad != 0) begin
            fails++;
            $display("FAIL md_wait_stall got %0d bad cycles exp 0", bad);
        end
        muldiv_done = 1;
        #1;
        checks++;
        if ({pc_stall, muldiv_start} !== 2'b00) begin
            fails++;
            $display("FAIL md_done_release got %b exp 00", {pc_stall, muldiv_start});
        end
        tick();
        idle();
        #1;
        checks++;
        if (stall_cycles !== 32'd11 || md_err !== 1'b0 || pc_stall !== 1'b0) begin
            fails++;
            $display("FAIL md_done_after got sc=%0d err=%b st=%b exp 11 0 0", stall_cycles, md_err, pc_stall);
        end
    endtask

    task automatic test_muldiv_timeout();
        int bad = 0;
        do_reset();
        id_valid = 1; id_is_muldiv = 1;
        tick();
        for (int i = 0; i < 39; i++) begin
            if (pc_stall !== 1'b1) bad++;
            tick();
        end
        checks++;
        if (bad != 0 || pc_stall !== 1'b0) begin
            fails++;
            $display("FAIL md_timeout_release got bad=%0d st=%b exp 0 0", bad, pc_stall);
        end
        tick();
        idle();
        tick();
        tick();
        checks++;
        if (md_err !== 1'b1 || stall_cycles !== 32'd40) begin
            fails++;
            $display("FAIL md_timeout_err got err=%b sc=%0d exp 1 40", md_err, stall_cycles);
        end
        // Done coincides with the final timeout cycle.
        do_reset();
        checks++;
        if (md_err !== 1'b0) begin
            fails++;
            $display("FAIL md_err_clear got %b exp 0", md_err);
        end
        id_valid = 1; id_is_muldiv = 1;
        for (int i = 0; i < 40; i++) tick();
        muldiv_done = 1;
        #1;
        checks++;
        if (pc_stall !== 1'b0) begin
            fails++;
            $display("FAIL md_coincide_release got %b exp 0", pc_stall);
        end
        tick();
        idle();
        #1;
        checks++;
        if (md_err !== 1'b0) begin
            fails++;
            $display("FAIL md_coincide_err got %b exp 0", md_err);
        end
    endtask

    task automatic test_branch();
        do_reset();
        branch_taken = 1;
        #1;
        checks++;
        if ({if_id_flush, pc_stall} !== 2'b10) begin
            fails++;
            $display("FAIL branch_flush got %b exp 10", {if_id_flush, pc_stall});
        end
        tick();
        idle();
        checks++;
        if (flush_count !== 16'd1) begin
            fails++;
            $display("FAIL flush_cnt got %0d exp 1", flush_count);
        end
        branch_taken = 1;
        exe_is_load = 1; exe_wena = 1; exe_waddr = 5'd3;
        id_valid = 1; id_rt = 5'd3; id_rena2 = 1;
        #1;
        checks++;
        if ({if_id_flush, pc_stall} !== 2'b01) begin
            fails++;
            $display("FAIL branch_with_stall got %b exp 01", {if_id_flush, pc_stall});
        end
        tick();
        exe_is_load = 0; exe_wena = 0; exe_waddr = 0;
        mem_waddr = 5'd3; mem_wena = 1;
        #1;
        checks++;
        if ({if_id_flush, pc_stall, fwd_rt_sel} !== 4'b1010) begin
            fails++;
            $display("FAIL branch_reeval got %b exp 1010", {if_id_flush, pc_stall, fwd_rt_sel});
        end
        tick();
        idle();
        muldiv_done = 1;
        #1;
        checks++;
        if (flush_count !== 16'd2 || pc_stall !== 1'b0) begin
            fails++;
            $display("FAIL flush_cnt2 got fc=%0d st=%b exp 2 0", flush_count, pc_stall);
        end
        tick();
        idle();
    endtask

    task automatic test_rst_in_mdwait();
        do_reset();
        id_valid = 1; id_is_muldiv = 1;
        tick();
        tick();
        tick();
        rst = 1;
        #1;
        checks++;
        if (pc_stall !== 1'b0) begin
            fails++;
            $display("FAIL rst_md_during got %b exp 0", pc_stall);
        end
        tick();
        rst = 0;
        idle();
        #1;
        checks++;
        if ({pc_stall, muldiv_start, if_id_stall} !== 3'b000) begin
            fails++;
            $display("FAIL rst_md_after got %b exp 000", {pc_stall, muldiv_start, if_id_stall});
        end
        id_valid = 1; id_is_muldiv = 1;
        #1;
        checks++;
        if (muldiv_start !== 1'b1) begin
            fails++;
            $display("FAIL rst_md_reissue got %b exp 1", muldiv_start);
        end
        tick();
        idle();
    endtask

    initial begin
        idle();
        rst = 1;
        test_reset();
        test_load_use();
        test_zero_reg_fwd();
        test_muldiv_done();
        test_muldiv_timeout();
        test_branch();
        test_rst_in_mdwait();
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
- Central pipeline sequencing controller for the 5-stage core (IF/ID/EXE/MEM/WB).
- Decides per cycle whether PC and IF/ID hold, whether a bubble enters ID/EXE, and whether IF/ID is flushed.
- Generates ID-stage forwarding selects for rs/rt.
- Sequences multi-cycle mult/div issue with a start/done handshake, a timeout watchdog and stall/flush performance counters.

Parameters:
- MD_TIMEOUT, 40: maximum MD_WAIT cycles before forced release.
- CNT_W, 32: width of stall_cycles counter.

Ports:
- clk  in  1  core clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- id_valid  in  1  ID holds a real instruction
- id_rs  in  5  ID source register 1
- id_rt  in  5  ID source register 2
- id_rena1  in  1  rs is read
- id_rena2  in  1  rt is read
- id_is_muldiv  in  1  ID instruction is mult/multu/div/divu
- branch_taken  in  1  branch/jump resolved taken in ID
- exe_waddr  in  5  EXE destination register
- exe_wena  in  1  EXE writes RF
- exe_is_load  in  1  EXE instruction is a load
- mem_waddr  in  5  MEM destination register
- mem_wena  in  1  MEM writes RF
- muldiv_done  in  1  mult/div unit result ready (1-cycle pulse)
- pc_stall  out  1  hold PC
- if_id_stall  out  1  hold IF/ID register
- id_exe_bubble  out  1  load NOP into ID/EXE
- if_id_flush  out  1  clear IF/ID (squash fetched slot)
- muldiv_start  out  1  1-cycle start pulse to mult/div unit
- fwd_rs_sel  out  2  00 RF, 01 EXE, 10 MEM
- fwd_rt_sel  out  2  same encoding
- md_err  out  1  sticky: mult/div timeout occurred
- stall_cycles  out  CNT_W  cycles with pc_stall=1
- flush_count  out  16  number of if_id_flush pulses, saturating

Behaviour:
- Clock clk. Reset rst is synchronous and active-high.
- Reset response: state=RUN, md counter=0, md_err=0, stall_cycles=0, flush_count=0.
- Combinational outputs evaluate to 0 / 00 while rst=1.
- Register match rule: a producer matches operand X only if producer wena=1, the read-enable for X is 1, waddr==X and waddr!=0. $0 never forwards or stalls.
- Forwarding (combinational, all states):
  - EXE match -> 01.
  - Else MEM match -> 10.
  - Else 00.
  - EXE has priority over MEM.
- load_use = id_valid & exe_is_load & EXE match on rs or rt.
- States: RUN, LOAD_WAIT, MD_WAIT. Priority within RUN/LOAD_WAIT is load_use > muldiv > branch.
- RUN:
  - If load_use: pc_stall=if_id_stall=id_exe_bubble=1, next LOAD_WAIT.
  - Else if id_valid & id_is_muldiv: muldiv_start=1, pc_stall=if_id_stall=id_exe_bubble=1, counter cleared, next MD_WAIT.
  - Else if branch_taken: if_id_flush=1, no stall, stay RUN.
  - Else all control 0.
- LOAD_WAIT:
  - Lasts one cycle. The load is now in MEM, so forwarding yields 10.
  - load_use check is masked.
  - Muldiv and branch rules are evaluated exactly as in RUN, with the same next-state targets; otherwise next state is RUN.
- MD_WAIT:
  - pc_stall=if_id_stall=id_exe_bubble=1 every cycle and the counter increments.
  - muldiv_start=0. branch_taken is ignored because the muldiv is not a branch.
  - On muldiv_done=1: all stalls=0 that same cycle (muldiv instruction advances), next RUN.
  - If the counter reaches MD_TIMEOUT-1 without done: set md_err, release as above, next RUN.
  - If done and timeout coincide, done wins and md_err is not set.
- muldiv_done outside MD_WAIT is ignored.
- Branch with a stall in the same cycle: no flush. The branch is re-evaluated when ID is released.
- Counters:
  - stall_cycles increments every cycle pc_stall=1 and wraps at 2^CNT_W.
  - flush_count saturates at 16'hFFFF.
- rst asserted mid-MD_WAIT: next cycle is RUN with no stall. No muldiv_start is reissued unless ID still presents the instruction.

Decomposition:
- Shared define file adds:
  - state encodings PC_RUN=2'd0, PC_LOAD_WAIT=2'd1, PC_MD_WAIT=2'd2;
  - forwarding selects FWD_RF/FWD_EXE/FWD_MEM;
  - MULT/DIV func codes used by the decoder to drive id_is_muldiv.
- One sub-module, fwd_sel: purely combinational match/priority logic, instantiated twice (rs, rt). Its EXE-match output also feeds load_use.

Test Plan:
- rst=1 for 2 cycles with arbitrary inputs -> all outputs 0, stall_cycles=0, state RUN.
- EXE load writes $8, ID reads rs=$8 with rena1=1 -> cycle0 stall+bubble, fwd_rs_sel=01. Cycle1 (mem_waddr=8, exe bubble) -> no stall, fwd_rs_sel=10. stall_cycles=1.
- exe_waddr=0 with exe_is_load=1, ID rs=0 -> no stall, fwd 00. EXE and MEM both write $5, rt=$5 -> fwd_rt_sel=01.
- ID div, done after 10 MD_WAIT cycles -> muldiv_start single pulse on issue, stalls for 11 cycles, released on done cycle, md_err=0, stall_cycles=11.
- ID div, done never arrives, MD_TIMEOUT=40 -> release after 40 MD_WAIT cycles, md_err=1 sticky until rst. Done and timeout on the same cycle -> md_err=0.
- branch_taken alone -> one if_id_flush pulse, flush_count=1. branch_taken with load_use -> no flush. rst during MD_WAIT -> RUN next cycle, all stalls 0.
